// File: rtl/cmd_frame_asm.sv
// Assembles UART bytes into cmd/data frames and returns response bytes to the transmitter.
// Build option: define CMD_CHECKSUM_EN for 4-byte frames with a trailing checksum byte.
module cmd_frame_asm #(
    parameter int TMO_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frm_err
);

`ifdef CMD_CHECKSUM_EN
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO, WAIT_CHK} rx_state_t;
`else
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} rx_state_t;
`endif
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t            rx_state_q;
    logic [TMO_WIDTH-1:0] tmo_q;
    logic [TMO_WIDTH-1:0] tmo_d;
    logic                 lock_q;
    logic                 consume;
    logic [7:0]           sh_cmd_q;
    logic [7:0]           sh_hi_q;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]           sh_lo_q;
    logic [7:0]           chk_sum;
`endif
    logic [7:0]           cmd_q;
    logic [15:0]          data_q;
    logic                 cmd_rdy_q;
    logic                 frm_err_q;

    tx_state_t            tx_state_q;
    logic                 trmt_q;
    logic [7:0]           tx_data_q;
    logic                 resp_sent_q;
    logic [7:0]           pend_q;
    logic                 pend_vld_q;

    // The lockout blocks the still-high rx_rdy in the cycle after a consume.
    assign consume    = rx_rdy & ~lock_q;
    assign clr_rx_rdy = consume;
    assign tmo_d      = tmo_q + {{(TMO_WIDTH-1){1'b0}}, 1'b1};
`ifdef CMD_CHECKSUM_EN
    assign chk_sum    = sh_cmd_q + sh_hi_q + sh_lo_q + rx_data;
`endif

    assign cmd       = cmd_q;
    assign data      = data_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frm_err   = frm_err_q;
    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= WAIT_CMD;
            tmo_q      <= '0;
            lock_q     <= 1'b0;
            cmd_q      <= '0;
            data_q     <= '0;
            cmd_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            lock_q    <= consume;
            frm_err_q <= 1'b0;
            if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
            // A byte arriving on the last idle cycle still counts, so consume outranks timeout.
            if (consume) begin
                tmo_q <= '0;
                case (rx_state_q)
                    WAIT_CMD: begin
                        sh_cmd_q   <= rx_data;
                        cmd_rdy_q  <= 1'b0;
                        rx_state_q <= WAIT_HI;
                    end
                    WAIT_HI: begin
                        sh_hi_q    <= rx_data;
                        rx_state_q <= WAIT_LO;
                    end
`ifdef CMD_CHECKSUM_EN
                    WAIT_LO: begin
                        sh_lo_q    <= rx_data;
                        rx_state_q <= WAIT_CHK;
                    end
                    WAIT_CHK: begin
                        if (chk_sum == 8'hFF) begin
                            cmd_q     <= sh_cmd_q;
                            data_q    <= {sh_hi_q, sh_lo_q};
                            cmd_rdy_q <= 1'b1;
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                        rx_state_q <= WAIT_CMD;
                    end
`else
                    WAIT_LO: begin
                        cmd_q      <= sh_cmd_q;
                        data_q     <= {sh_hi_q, rx_data};
                        cmd_rdy_q  <= 1'b1;
                        rx_state_q <= WAIT_CMD;
                    end
`endif
                    default: rx_state_q <= WAIT_CMD;
                endcase
            end else if (rx_state_q == WAIT_CMD) begin
                tmo_q <= '0;
            end else if (&tmo_d) begin
                tmo_q      <= '0;
                frm_err_q  <= 1'b1;
                rx_state_q <= WAIT_CMD;
            end else begin
                tmo_q <= tmo_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            trmt_q      <= 1'b0;
            tx_data_q   <= '0;
            resp_sent_q <= 1'b0;
            pend_vld_q  <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data_q  <= resp;
                        trmt_q     <= 1'b1;
                        tx_state_q <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (tx_done) begin
                        resp_sent_q <= 1'b1;
                        if (pend_vld_q) begin
                            tx_data_q  <= pend_q;
                            trmt_q     <= 1'b1;
                            pend_vld_q <= send_resp;
                            if (send_resp) pend_q <= resp;
                        end else if (send_resp) begin
                            tx_data_q <= resp;
                            trmt_q    <= 1'b1;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else if (send_resp) begin
                        pend_q     <= resp;
                        pend_vld_q <= 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_asm.sv
// Bench for cmd_frame_asm: queue-based reference model checked every cycle plus directed vectors.
module tb_cmd_frame_asm;
    localparam int TMO_W    = 4;
    localparam int TMO_IDLE = (1 << TMO_W) - 1;
`ifdef CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        frm_err;

    cmd_frame_asm #(.TMO_WIDTH(TMO_W)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data),
        .tx_done(tx_done), .resp_sent(resp_sent), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of received bytes; TX is a busy flag plus a waiting list.
    logic [7:0]  m_frame[$];
    logic [7:0]  m_pend[$];
    int          m_idle;
    bit          m_prev_c;
    bit          m_busy;
    bit          run = 1'b0;
    logic [7:0]  e_cmd, e_txd;
    logic [15:0] e_data;
    logic        e_rdy, e_err, e_trmt, e_sent;

    always @(posedge clk) begin : model
        bit         c;
        logic [7:0] sum;
        if (rst) begin
            run = 1'b1;
            m_frame.delete();
            m_pend.delete();
            m_idle = 0; m_prev_c = 1'b0; m_busy = 1'b0;
            e_cmd = 8'h00; e_data = 16'h0000; e_rdy = 1'b0; e_err = 1'b0;
            e_trmt = 1'b0; e_txd = 8'h00; e_sent = 1'b0;
        end else begin
            c = rx_rdy && !m_prev_c;
            e_err = 1'b0;
            if (clr_cmd_rdy) e_rdy = 1'b0;
            if (c) begin
                if (m_frame.size() == 0) e_rdy = 1'b0;
                m_frame.push_back(rx_data);
                m_idle = 0;
                if (m_frame.size() == FRAME_LEN) begin
                    sum = 8'h00;
                    foreach (m_frame[i]) sum = sum + m_frame[i];
                    if (FRAME_LEN == 4 && sum != 8'hFF) e_err = 1'b1;
                    else begin
                        e_cmd = m_frame[0]; e_data = {m_frame[1], m_frame[2]}; e_rdy = 1'b1;
                    end
                    m_frame.delete();
                end
            end else if (m_frame.size() != 0) begin
                m_idle++;
                if (m_idle == TMO_IDLE) begin
                    e_err = 1'b1; m_frame.delete(); m_idle = 0;
                end
            end
            m_prev_c = c;

            e_trmt = 1'b0; e_sent = 1'b0;
            if (!m_busy) begin
                if (send_resp) begin e_txd = resp; e_trmt = 1'b1; m_busy = 1'b1; end
            end else if (tx_done) begin
                e_sent = 1'b1;
                if (m_pend.size() > 0) begin
                    e_txd = m_pend.pop_front(); e_trmt = 1'b1;
                    if (send_resp) m_pend.push_back(resp);
                end else if (send_resp) begin
                    e_txd = resp; e_trmt = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (send_resp) begin
                m_pend.delete(); m_pend.push_back(resp);
            end
        end
    end

    int cyc = 0;
    int clr_cnt = 0, err_cnt = 0, clr_cyc = 0, err_cyc = 0;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (run) begin
            chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, rx_rdy && !m_prev_c});
            chk("cmd", {24'd0, cmd}, {24'd0, e_cmd});
            chk("data", {16'd0, data}, {16'd0, e_data});
            chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, e_rdy});
            chk("frm_err", {31'd0, frm_err}, {31'd0, e_err});
            chk("trmt", {31'd0, trmt}, {31'd0, e_trmt});
            chk("tx_data", {24'd0, tx_data}, {24'd0, e_txd});
            chk("resp_sent", {31'd0, resp_sent}, {31'd0, e_sent});
        end
        if (clr_rx_rdy === 1'b1) begin clr_cnt++; clr_cyc = cyc; end
        if (frm_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap);
        rx_data = b; rx_rdy = 1'b1;
        tick(2);
        rx_rdy = 1'b0;
        tick(gap);
    endtask

    task automatic put_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int gap);
        logic [7:0] s;
        put_byte(b0, gap);
        put_byte(b1, gap);
        put_byte(b2, gap);
        s = b0 + b1 + b2;
        if (FRAME_LEN == 4) put_byte(8'hFF - s, gap);
    endtask

    task automatic expect_timeout(input string name);
        int e0;
        e0 = err_cnt;
        for (int i = 0; i < 40 && err_cnt == e0; i++) tick(1);
        chk({name, "_err_seen"}, err_cnt - e0, 1);
        chk({name, "_latency"}, err_cyc - clr_cyc - 1, TMO_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0;
        logic [7:0] last;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_data", data, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_trmt", trmt, 0);
        chk("rst_tx_data", tx_data, 8'h00);

        // Frame 02,12,34 with bytes 10 cycles apart and rx_rdy held 2 cycles.
        n0 = clr_cnt;
        put_frame(8'h02, 8'h12, 8'h34, 8);
        chk("t1_clr_pulses", clr_cnt - n0, FRAME_LEN);
        chk("t1_cmd", cmd, 8'h02);
        chk("t1_data", data, 16'h1234);
        chk("t1_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1; tick(1); clr_cmd_rdy = 1'b0;
        chk("t1_rdy_cleared", cmd_rdy, 0);

        // New frame start drops cmd_rdy while holding the old cmd/data.
        put_frame(8'h05, 8'h00, 8'h80, 2);
        chk("t2_cmd_a", cmd, 8'h05);
        chk("t2_rdy_a", cmd_rdy, 1);
        put_byte(8'h03, 2);
        chk("t2_rdy_drop", cmd_rdy, 0);
        chk("t2_cmd_hold", cmd, 8'h05);
        chk("t2_data_hold", data, 16'h0080);
        put_byte(8'hFF, 2);
        put_byte(8'hF0, 2);
        if (FRAME_LEN == 4) put_byte(8'h0D, 2);
        chk("t2_cmd_b", cmd, 8'h03);
        chk("t2_data_b", data, 16'hFFF0);

        // Completion and clr_cmd_rdy in the same cycle: completion wins.
        put_byte(8'h07, 2);
        put_byte(8'h01, 2);
        last = 8'h02;
        if (FRAME_LEN == 4) begin put_byte(8'h02, 2); last = 8'hF5; end
        rx_data = last; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        tick(1);
        rx_rdy = 1'b0;
        chk("t2c_rdy_wins", cmd_rdy, 1);
        chk("t2c_data", data, 16'h0102);

        // Inter-byte timeout after 06,AA.
        put_byte(8'h06, 2);
        put_byte(8'hAA, 0);
        expect_timeout("t3");
        chk("t3_cmd_kept", cmd, 8'h07);
        chk("t3_data_kept", data, 16'h0102);
        tick(3);
        put_frame(8'h01, 8'h00, 8'h00, 2);
        chk("t3_cmd_next", cmd, 8'h01);
        chk("t3_data_next", data, 16'h0000);
        chk("t3_rdy_next", cmd_rdy, 1);

        // Response path: direct launch, pending buffer, overwrite, simultaneous done/send.
        resp = 8'hA5; send_resp = 1'b1; tick(1); send_resp = 1'b0;
        chk("t4_trmt_a5", trmt, 1);
        chk("t4_txd_a5", tx_data, 8'hA5);
        tick(1);
        chk("t4_trmt_once", trmt, 0);
        resp = 8'h5B; send_resp = 1'b1; tick(1); send_resp = 1'b0;
        chk("t4_no_trmt_busy", trmt, 0);
        tick(2);
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        chk("t4_sent_1", resp_sent, 1);
        chk("t4_trmt_5b", trmt, 1);
        chk("t4_txd_5b", tx_data, 8'h5B);
        tick(2);
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        chk("t4_sent_2", resp_sent, 1);
        chk("t4_trmt_idle", trmt, 0);
        resp = 8'h3C; send_resp = 1'b1; tick(1);
        chk("t4_txd_3c", tx_data, 8'h3C);
        resp = 8'h11; tick(1);
        resp = 8'h22; tick(1); send_resp = 1'b0;
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        chk("t4_overwrite", tx_data, 8'h22);
        chk("t4_trmt_22", trmt, 1);
        tick(1);
        resp = 8'h99; send_resp = 1'b1; tx_done = 1'b1; tick(1);
        send_resp = 1'b0; tx_done = 1'b0;
        chk("t4_direct_trmt", trmt, 1);
        chk("t4_direct_txd", tx_data, 8'h99);
        chk("t4_direct_sent", resp_sent, 1);
        tick(1);
        tx_done = 1'b1; tick(1); tx_done = 1'b0;
        chk("t4_final_trmt", trmt, 0);

        // Reset mid-frame discards the partial frame silently.
        put_byte(8'h02, 2);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("t5_cmd", cmd, 8'h00);
        chk("t5_data", data, 16'h0000);
        chk("t5_rdy", cmd_rdy, 0);
        chk("t5_frm_err", frm_err, 0);
        e0 = err_cnt;
        tick(20);
        chk("t5_no_err", err_cnt - e0, 0);
        put_frame(8'h04, 8'h00, 8'h10, 2);
        chk("t5_cmd_next", cmd, 8'h04);
        chk("t5_data_next", data, 16'h0010);

`ifdef CMD_CHECKSUM_EN
        put_byte(8'h02, 2); put_byte(8'h12, 2); put_byte(8'h34, 2); put_byte(8'hB7, 2);
        chk("t6_good_rdy", cmd_rdy, 1);
        chk("t6_good_data", data, 16'h1234);
        e0 = err_cnt;
        put_byte(8'h02, 2); put_byte(8'h12, 2); put_byte(8'h34, 2); put_byte(8'hB6, 2);
        chk("t6_bad_err", err_cnt - e0, 1);
        chk("t6_bad_rdy", cmd_rdy, 0);
        chk("t6_bad_data", data, 16'h1234);
        put_byte(8'h06, 2); put_byte(8'hAA, 2); put_byte(8'hBB, 0);
        expect_timeout("t6_chk");
`endif

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_frame_asm.md
Name: cmd_frame_asm

Overview:
Upstream front end of cmd_cfg. It takes raw bytes from the UART receiver and assembles them into 24-bit command frames (cmd, data[15:8], data[7:0]). It presents each completed frame on cmd/data with a cmd_rdy/clr_cmd_rdy handshake. It also returns cmd_cfg's resp byte to the UART transmitter, with a one-entry pending buffer for back-to-back responses.

Parameters:
TMO_WIDTH, 16, width of the inter-byte timeout counter; the frame is abandoned when the counter saturates (2^TMO_WIDTH-1 cycles idle mid-frame).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
rx_rdy  input  1  UART receiver byte valid; held high until cleared
rx_data  input  8  received byte
clr_rx_rdy  output  1  combinational; high in the cycle a byte is consumed
cmd  output  8  opcode of last completed frame
data  output  16  payload of last completed frame, first payload byte in [15:8]
cmd_rdy  output  1  completed frame available
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
send_resp  input  1  one-cycle request to transmit resp
resp  input  8  response byte
trmt  output  1  one-cycle start pulse to UART transmitter
tx_data  output  8  byte to transmit
tx_done  input  1  transmitter finished current byte
resp_sent  output  1  one-cycle pulse per completed response
frm_err  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (rst=1 at clk edge): cmd=0, data=0, cmd_rdy=0, trmt=0, tx_data=0, resp_sent=0, frm_err=0. Both FSMs go to their first state, the timeout counter clears and the pending buffer empties. Reset mid-frame discards partial bytes without a frm_err pulse.
- Byte consume: occurs when rx_rdy=1 and the lockout flag is clear. In that cycle clr_rx_rdy=1 and the byte is registered. The lockout flag is set for the next cycle only, so an rx_rdy that is still high then is ignored.
- RX FSM: WAIT_CMD -> WAIT_HI -> WAIT_LO -> (WAIT_CHK, macro only) -> WAIT_CMD. Each transition advances on a consume. Bytes go to shadow registers sh_cmd, sh_hi and sh_lo.
- Frame completion (consume in the final state): cmd<=sh_cmd and data<={sh_hi,rx_data} on that edge, and cmd_rdy=1 on the same edge. cmd and data hold until the next completion.
- cmd_rdy clear: on clr_cmd_rdy=1, or on a consume in WAIT_CMD (start of a new frame). If completion coincides with clr_cmd_rdy, completion wins and cmd_rdy stays 1.
- Timeout: the counter clears on every consume and in WAIT_CMD, and increments in every other state. At all-ones, the FSM returns to WAIT_CMD, the counter clears and frm_err pulses. cmd, data and cmd_rdy are unchanged.
- TX FSM, TX_IDLE / TX_BUSY:
  - TX_IDLE with send_resp: tx_data<=resp, trmt=1 on the next cycle only, then go to TX_BUSY. Latency is 1 cycle from send_resp to trmt.
  - TX_BUSY with send_resp: resp is written to the pending buffer (pend_vld=1). If the buffer is already full, the newest byte overwrites it.
  - TX_BUSY with tx_done: resp_sent pulses. If pend_vld=1, the pending byte is launched (tx_data<=pend, trmt=1 next cycle, pend_vld cleared, stay in TX_BUSY). Otherwise go to TX_IDLE.
  - tx_done and send_resp in the same cycle with pend_vld=0: the new resp launches directly (trmt next cycle) and resp_sent pulses.
- RX and TX paths are independent. Simultaneous events in the two paths never interact.

Optional Feature:
CMD_CHECKSUM_EN
- Defined: frames are 4 bytes; the 4th byte is a checksum. On the 4th consume, if (sh_cmd+sh_hi+sh_lo+chk) mod 256 == 8'hFF, the frame completes as above. Otherwise the frame is dropped: cmd, data and cmd_rdy are unchanged, frm_err pulses and the FSM returns to WAIT_CMD. The frame completes on the 4th byte, and the timeout also covers WAIT_CHK.
- Undefined: WAIT_CHK does not exist and frames are 3 bytes. frm_err fires only on timeout.

Test Plan:
- Bytes 02,12,34, spaced 10 cycles apart, with rx_rdy held 2 cycles each -> exactly 3 clr_rx_rdy pulses; cmd=02, data=1234, cmd_rdy=1 on the edge of the 3rd consume; then clr_cmd_rdy -> cmd_rdy=0 next cycle.
- Frame 05,00,80 completes; next frame byte 03 arrives before clr_cmd_rdy -> cmd_rdy drops on that consume and cmd stays 05 until bytes FF,F0 complete -> cmd=03, data=FFF0.
- TMO_WIDTH=4: bytes 06,AA then silence -> frm_err pulse 15 cycles after the AA consume; following 01,00,00 -> cmd=01, data=0000.
- send_resp with resp=A5 in TX_IDLE -> trmt 1 cycle later, tx_data=A5; send_resp with 5B while busy; tx_done -> resp_sent pulse, trmt next cycle with tx_data=5B; second tx_done -> resp_sent, back to TX_IDLE.
- rst=1 asserted after byte 02 of a frame -> all outputs 0 next edge, no frm_err; bytes 04,00,10 then produce cmd=04, data=0010.
- CMD_CHECKSUM_EN: 02,12,34,B7 -> cmd_rdy=1, data=1234; 02,12,34,B6 -> frm_err pulse, cmd_rdy stays 0.
